// File: rtl/serial_pkg.sv
// Shared constants, mode encodings and FSM state type for the 8051-style serial port.
// The transmitter and the (future) receiver both import this package.
package serial_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'd0;
    localparam logic [1:0] MODE_UART8  = 2'd1;
    localparam logic [1:0] MODE_UART9F = 2'd2;
    localparam logic [1:0] MODE_UART9T = 2'd3;

    localparam int DIV_M0 = 12;
    localparam int DIV_M2 = 64;
    localparam int DIV_T1 = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        NINTH = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    // Terminal count of the baud divider; SMOD halves the UART intervals only.
    function automatic logic [5:0] div_limit(input logic [1:0] mode, input logic smod);
        logic [5:0] lim;
        case (mode)
            MODE_SHIFT:  lim = 6'(DIV_M0 - 1);
            MODE_UART9F: lim = smod ? 6'(DIV_M2 / 2 - 1) : 6'(DIV_M2 - 1);
            default:     lim = smod ? 6'(DIV_T1 / 2 - 1) : 6'(DIV_T1 - 1);
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Signal bundle between the SFR/timer logic (master) and the serial transmitter (slave).
// sbuf_wr is a one-cycle strobe honoured only while busy is low; there is no ready back-pressure.
interface serial_tx_if;
    import serial_pkg::*;

    logic       sbuf_wr;
    logic [7:0] sbuf_din;
    logic [1:0] mode;
    logic       tb8;
    logic       smod;
    logic       t1_ovf;
    logic       txd;
    logic       txclk;
    logic       busy;
    logic       ti_set;
    tx_state_t  state;

    modport master (
        output sbuf_wr, sbuf_din, mode, tb8, smod, t1_ovf,
        input  txd, txclk, busy, ti_set, state
    );

    modport slave (
        input  sbuf_wr, sbuf_din, mode, tb8, smod, t1_ovf,
        output txd, txclk, busy, ti_set, state
    );

endinterface

// File: rtl/baud_gen.sv
// Free-running baud divider: one-cycle tick per bit interval, plus the mode-0 txclk phase.
// Counts clk in modes 0/2 and Timer 1 overflows in modes 1/3; never resynchronised to a write.
module baud_gen
    import serial_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       smod,
    input  logic       t1_ovf,
    output logic       tick,
    output logic       shift_low
);

    logic [5:0] cnt;
    logic [5:0] cnt_next;
    logic [5:0] limit;
    logic       step;

    always_comb begin
        limit    = div_limit(mode, smod);
        step     = (mode == MODE_SHIFT || mode == MODE_UART9F) ? 1'b1 : t1_ovf;
        // >= so a live mode/smod change that shrinks the interval cannot strand the count
        tick     = step && (cnt >= limit);
        cnt_next = cnt;
        if (tick) begin
            cnt_next = '0;
        end else if (step) begin
            cnt_next = cnt + 6'd1;
        end
        // The cycle after this one lies in the first half of a mode-0 bit interval
        shift_low = (cnt_next < 6'(DIV_M0 / 2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Transmit half of the 8051 serial port: serialises SBUF in SCON modes 0-3 and pulses ti_set.
// All outputs come straight from flops; the FSM state is mirrored on bus.state for debug.
module serial_tx
    import serial_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus
);

    tx_state_t  state, state_next;
    logic       lead, lead_next;
    logic [2:0] bit_cnt, bit_next;
    logic [7:0] data_q, data_next;
    logic [1:0] mode_q, mode_next;
    logic       tb8_q, tb8_next;
    logic       txd_q, txd_next;
    logic       txclk_q, txclk_next;
    logic       busy_q, busy_next;
    logic       ti_q, ti_next;
    logic [1:0] div_mode;
    logic       tick;
    logic       shift_low;

    assign div_mode = busy_q ? mode_q : bus.mode;

    baud_gen u_baud (
        .clk       (clk),
        .reset     (reset),
        .mode      (div_mode),
        .smod      (bus.smod),
        .t1_ovf    (bus.t1_ovf),
        .tick      (tick),
        .shift_low (shift_low)
    );

    // lead marks the wait for the first tick after a write, before any bit is on the line.
    always_comb begin
        state_next = state;
        lead_next  = lead;
        bit_next   = bit_cnt;
        data_next  = data_q;
        mode_next  = mode_q;
        tb8_next   = tb8_q;
        txd_next   = txd_q;
        ti_next    = 1'b0;

        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (bus.sbuf_wr) begin
                    data_next  = bus.sbuf_din;
                    mode_next  = bus.mode;
                    tb8_next   = bus.tb8;
                    lead_next  = 1'b1;
                    bit_next   = 3'd0;
                    state_next = (bus.mode == MODE_SHIFT) ? DATA : START;
                end
            end
            START: begin
                if (tick) begin
                    if (lead) begin
                        txd_next  = 1'b0;
                        lead_next = 1'b0;
                    end else begin
                        txd_next   = data_q[0];
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (lead) begin
                        txd_next  = data_q[0];
                        lead_next = 1'b0;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (mode_q == MODE_SHIFT) begin
                                state_next = IDLE;
                                txd_next   = 1'b1;
                                ti_next    = 1'b1;
                            end else if (mode_q == MODE_UART8) begin
                                state_next = STOP;
                                txd_next   = 1'b1;
                                ti_next    = 1'b1;
                            end else begin
                                state_next = NINTH;
                                txd_next   = tb8_q;
                            end
                        end else begin
                            txd_next = data_q[bit_next];
                        end
                    end
                end
            end
            NINTH: begin
                if (tick) begin
                    state_next = STOP;
                    txd_next   = 1'b1;
                    ti_next    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    txd_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase

        busy_next  = (state_next != IDLE);
        txclk_next = !(state_next == DATA && !lead_next &&
                       mode_next == MODE_SHIFT && shift_low);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lead    <= 1'b0;
            bit_cnt <= 3'd0;
            data_q  <= 8'd0;
            mode_q  <= MODE_SHIFT;
            tb8_q   <= 1'b0;
            txd_q   <= 1'b1;
            txclk_q <= 1'b1;
            busy_q  <= 1'b0;
            ti_q    <= 1'b0;
        end else begin
            state   <= state_next;
            lead    <= lead_next;
            bit_cnt <= bit_next;
            data_q  <= data_next;
            mode_q  <= mode_next;
            tb8_q   <= tb8_next;
            txd_q   <= txd_next;
            txclk_q <= txclk_next;
            busy_q  <= busy_next;
            ti_q    <= ti_next;
        end
    end

    assign bus.txd    = txd_q;
    assign bus.txclk  = txclk_q;
    assign bus.busy   = busy_q;
    assign bus.ti_set = ti_q;
    assign bus.state  = state;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: a table of frames with hand-computed wire bit patterns,
// plus a hand-written mid-frame reset sequence.
module tb_serial_tx;
    import serial_pkg::*;

    typedef struct {
        logic [1:0]  mode;
        logic        smod;
        logic        tb8;
        logic [7:0]  din;
        int          ovf_per;
        int          period;
        int          nbits;
        logic [10:0] bits;
    } vec_t;

    localparam int START_BUDGET = 400;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ovf_period = 0;
    vec_t vecs[8];

    serial_tx_if bus_if();

    serial_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial forever #5 clk = ~clk;

    initial begin : ovf_gen
        int cnt;
        cnt = 0;
        bus_if.t1_ovf = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ovf_period > 0) begin
                cnt = (cnt + 1) % ovf_period;
                bus_if.t1_ovf = (cnt == 0);
            end else begin
                bus_if.t1_ovf = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int abort_bit);
        int n, pre_bad, clk_bad, busy_bad, ti_bad, last, nb_done, b, j, p;
        int txd_bad[11];
        logic exp_clk, exp_ti;
        string tag;

        tag = $sformatf("m%0d_%02h", v.mode, v.din);
        p = v.period;
        for (int i = 0; i < 11; i++) txd_bad[i] = 0;
        pre_bad = 0; clk_bad = 0; busy_bad = 0; ti_bad = 0;

        ovf_period       = v.ovf_per;
        bus_if.mode      = v.mode;
        bus_if.smod      = v.smod;
        bus_if.tb8       = v.tb8;
        bus_if.sbuf_din  = v.din;
        bus_if.sbuf_wr   = 1'b1;
        step();
        bus_if.sbuf_wr = 1'b0;
        check({tag, " busy_after_accept"}, int'(bus_if.busy), 1);

        n = 0;
        while (((v.mode == MODE_SHIFT) ? bus_if.txclk : bus_if.txd) != 1'b0 && n < START_BUDGET) begin
            if (bus_if.txd !== 1'b1 || bus_if.busy !== 1'b1) pre_bad++;
            step();
            n++;
        end
        check({tag, " first_bit_seen"}, int'(n < START_BUDGET), 1);
        if (n >= START_BUDGET) return;
        check({tag, " line_before_first_bit"}, pre_bad, 0);

        last    = (abort_bit >= 0) ? abort_bit * p + p / 2 : v.nbits * p;
        nb_done = (abort_bit >= 0) ? abort_bit : v.nbits;
        for (int c = 0; c < last; c++) begin
            if (c > 0) step();
            b = c / p;
            j = c % p;
            if (bus_if.txd !== v.bits[b]) txd_bad[b]++;
            exp_clk = (v.mode == MODE_SHIFT) ? (j >= 6) : 1'b1;
            if (bus_if.txclk !== exp_clk) clk_bad++;
            if (bus_if.busy !== 1'b1) busy_bad++;
            exp_ti = (v.mode != MODE_SHIFT) && (c == (v.nbits - 1) * p);
            if (bus_if.ti_set !== exp_ti) ti_bad++;
            // Ignored write plus live tb8/mode changes while the frame is in flight
            if (c == 3 * p) begin
                bus_if.sbuf_wr  = 1'b1;
                bus_if.sbuf_din = ~v.din;
                bus_if.tb8      = ~v.tb8;
                bus_if.mode     = v.mode ^ 2'b01;
            end
            if (c == 3 * p + 1) bus_if.sbuf_wr = 1'b0;
        end
        for (int i = 0; i < nb_done; i++)
            check($sformatf("%s txd_bit%0d bad_cycles", tag, i), txd_bad[i], 0);
        check({tag, " txclk bad_cycles"}, clk_bad, 0);
        check({tag, " busy bad_cycles"}, busy_bad, 0);
        check({tag, " ti_set bad_cycles"}, ti_bad, 0);
        step();

        if (abort_bit >= 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check({tag, " abort txd"},    int'(bus_if.txd), 1);
            check({tag, " abort txclk"},  int'(bus_if.txclk), 1);
            check({tag, " abort busy"},   int'(bus_if.busy), 0);
            check({tag, " abort ti_set"}, int'(bus_if.ti_set), 0);
            check({tag, " abort state"},  int'(bus_if.state), int'(IDLE));
            pre_bad = 0;
            ti_bad  = 0;
            for (int c = 0; c < 3 * p; c++) begin
                step();
                if (bus_if.txd !== 1'b1 || bus_if.busy !== 1'b0) pre_bad++;
                if (bus_if.ti_set !== 1'b0) ti_bad++;
            end
            check({tag, " after_abort line bad_cycles"}, pre_bad, 0);
            check({tag, " after_abort ti_set pulses"}, ti_bad, 0);
        end else begin
            check({tag, " end txd"},    int'(bus_if.txd), 1);
            check({tag, " end txclk"},  int'(bus_if.txclk), 1);
            check({tag, " end busy"},   int'(bus_if.busy), 0);
            check({tag, " end ti_set"}, int'(bus_if.ti_set), (v.mode == MODE_SHIFT) ? 1 : 0);
        end
    endtask

    initial begin : main
        int bad_txd, bad_clk, bad_busy, bad_ti;
        vec_t abort_v;

        // bits[] is the wire sequence, first bit on the line in bit 0
        vecs[0] = '{MODE_UART8,  1'b0, 1'b0, 8'hA5, 4, 128, 10, 11'b011_0100_1010};
        vecs[1] = '{MODE_UART9T, 1'b1, 1'b1, 8'h00, 2,  32, 11, 11'b110_0000_0000};
        vecs[2] = '{MODE_UART9F, 1'b0, 1'b0, 8'hFF, 3,  64, 11, 11'b101_1111_1110};
        vecs[3] = '{MODE_SHIFT,  1'b0, 1'b0, 8'h3C, 0,  12,  8, 11'b000_0011_1100};
        vecs[4] = '{MODE_UART9F, 1'b1, 1'b1, 8'h96, 0,  32, 11, 11'b111_0010_1100};
        vecs[5] = '{MODE_UART8,  1'b1, 1'b0, 8'h0F, 1,  16, 10, 11'b010_0001_1110};
        vecs[6] = '{MODE_SHIFT,  1'b1, 1'b1, 8'hC5, 2,  12,  8, 11'b000_1100_0101};
        vecs[7] = '{MODE_UART9T, 1'b0, 1'b0, 8'h81, 1,  32, 11, 11'b101_0000_0010};
        abort_v = '{MODE_UART8,  1'b1, 1'b0, 8'h55, 1,  16, 10, 11'b010_1010_1010};

        bus_if.sbuf_wr  = 1'b0;
        bus_if.sbuf_din = 8'h00;
        bus_if.mode     = MODE_SHIFT;
        bus_if.tb8      = 1'b0;
        bus_if.smod     = 1'b0;
        reset           = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("reset txd",    int'(bus_if.txd), 1);
        check("reset txclk",  int'(bus_if.txclk), 1);
        check("reset busy",   int'(bus_if.busy), 0);
        check("reset ti_set", int'(bus_if.ti_set), 0);
        check("reset state",  int'(bus_if.state), int'(IDLE));

        bad_txd = 0; bad_clk = 0; bad_busy = 0; bad_ti = 0;
        for (int c = 0; c < 500; c++) begin
            step();
            if (bus_if.txd !== 1'b1) bad_txd++;
            if (bus_if.txclk !== 1'b1) bad_clk++;
            if (bus_if.busy !== 1'b0) bad_busy++;
            if (bus_if.ti_set !== 1'b0) bad_ti++;
        end
        check("idle txd bad_cycles",    bad_txd, 0);
        check("idle txclk bad_cycles",  bad_clk, 0);
        check("idle busy bad_cycles",   bad_busy, 0);
        check("idle ti_set bad_cycles", bad_ti, 0);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], -1);

        // Reset during d3 of a mode-1 frame, then a clean frame afterwards
        run_frame(abort_v, 4);
        run_frame(vecs[5], -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
